// File: rtl/wb_periph_ic_1xn_if.sv
// Wishbone bus bundle used for the upstream port of wb_periph_ic_1xn.
// The master drives the request and the slave drives the response.
interface wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   adr;
    logic [DATA_W-1:0]   dat_w;
    logic [DATA_W-1:0]   dat_r;
    logic                cyc;
    logic                stb;
    logic                we;
    logic [DATA_W/8-1:0] sel;
    logic                ack;
    logic                err;

    modport master (
        output adr, dat_w, cyc, stb, we, sel,
        input  dat_r, ack, err
    );

    modport slave (
        input  adr, dat_w, cyc, stb, we, sel,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_periph_ic_1xn.sv
// Registered 1-to-N Wishbone peripheral decoder.
// The upstream address is truncated to the subsystem window, decoded against a
// per-slave base/limit map (lowest index wins on overlap) and forwarded to one
// downstream port. Unmapped accesses get an error response.
// Optional bus watchdog: define WB_PERIPH_IC_TIMEOUT_EN to terminate hung
// transfers with an error and latch the offset of the first timeout.
module wb_periph_ic_1xn #(
    parameter int WB_ADDR_WIDTH     = 32,
    parameter int WB_DATA_WIDTH     = 32,
    parameter int SUBSYS_ADDR_WIDTH = 12,
    parameter int N_SLAVES          = 4,
    parameter logic [N_SLAVES*SUBSYS_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = '0,
    parameter logic [N_SLAVES*SUBSYS_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '1,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    wb_if.slave                                   s,
    output logic [N_SLAVES*WB_ADDR_WIDTH-1:0]     m_adr,
    output logic [N_SLAVES*WB_DATA_WIDTH-1:0]     m_dat_w,
    output logic [N_SLAVES*(WB_DATA_WIDTH/8)-1:0] m_sel,
    output logic [N_SLAVES-1:0]                   m_we,
    output logic [N_SLAVES-1:0]                   m_cyc,
    output logic [N_SLAVES-1:0]                   m_stb,
    input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]     m_dat_r,
    input  logic [N_SLAVES-1:0]                   m_ack,
    input  logic [N_SLAVES-1:0]                   m_err,
    output logic                                  to_valid,
    output logic [SUBSYS_ADDR_WIDTH-1:0]          to_addr,
    input  logic                                  to_clr
);
    localparam int AW    = WB_ADDR_WIDTH;
    localparam int DW    = WB_DATA_WIDTH;
    localparam int SW    = SUBSYS_ADDR_WIDTH;
    localparam int SEL_W = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     off_q;
    logic [DW-1:0]     dat_w_q;
    logic [SEL_W-1:0]  sel_q;
    logic              we_q;
    logic [N_SLAVES-1:0] sel_oh_q;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdat_q, rdat_d;
    logic              load;
    logic [N_SLAVES-1:0] hit;
    logic              active;
    logic              sel_ack, sel_err;
    logic [DW-1:0]     sel_rdat;
    logic              unused_bits;

    // One-hot address decode; scanning downward lets the lowest index win.
    function automatic logic [N_SLAVES-1:0] decode(input logic [SW-1:0] off);
        logic [N_SLAVES-1:0] oh;
        oh = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (off >= SLAVE_ADDR_BASE[i*SW +: SW] && off <= SLAVE_ADDR_LIMIT[i*SW +: SW]) begin
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    assign hit     = decode(s.adr[SW-1:0]);
    assign active  = (state_q == ACTIVE);
    assign sel_ack = |(m_ack & sel_oh_q);
    assign sel_err = |(m_err & sel_oh_q);

    // Pick the read data of the selected slave; other slaves are masked out.
    always_comb begin
        sel_rdat = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_oh_q[i]) begin
                sel_rdat = sel_rdat | m_dat_r[i*DW +: DW];
            end
        end
    end

    // Control strobes go only to the selected slave while a transfer is open.
    assign m_cyc = active ? sel_oh_q : '0;
    assign m_stb = active ? sel_oh_q : '0;
    assign m_we  = (active && we_q) ? sel_oh_q : '0;

    // Address, data and selects are broadcast; the address is the window offset.
    for (genvar g = 0; g < N_SLAVES; g++) begin : g_bcast
        assign m_adr[g*AW +: AW]         = AW'(off_q);
        assign m_dat_w[g*DW +: DW]       = dat_w_q;
        assign m_sel[g*SEL_W +: SEL_W]   = sel_q;
    end

    assign s.ack   = ack_q;
    assign s.err   = err_q;
    assign s.dat_r = rdat_q;

`ifdef WB_PERIPH_IC_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0]   timer_q;
    logic          to_fire;
    logic          to_valid_q;
    logic [SW-1:0] to_addr_q;

    assign to_valid    = to_valid_q;
    assign to_addr     = to_addr_q;
    assign unused_bits = ^s.adr[AW-1:SW];
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    // Without the watchdog the status outputs are constant and to_clr is inert.
    assign to_valid    = 1'b0;
    assign to_addr     = '0;
    assign unused_bits = ^{s.adr[AW-1:SW], to_clr};
`endif

    // Next-state and response decision for the transfer FSM.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = rdat_q;
        load    = 1'b0;
`ifdef WB_PERIPH_IC_TIMEOUT_EN
        to_fire = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (s.cyc && s.stb) begin
                    load = 1'b1;
                    if (|hit) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdat_d  = '0;
                    end
                end
            end
            ACTIVE: begin
                if (!s.cyc) begin
                    // Master abandoned the cycle: close it silently.
                    state_d = IDLE;
                end else if (sel_ack || sel_err) begin
                    state_d = RESP;
                    err_d   = sel_err;
                    ack_d   = !sel_err;
                    rdat_d  = we_q ? '0 : sel_rdat;
`ifdef WB_PERIPH_IC_TIMEOUT_EN
                end else if (timer_q == TO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    to_fire = 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured request and upstream response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            off_q    <= '0;
            dat_w_q  <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            sel_oh_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rdat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            if (load) begin
                off_q    <= s.adr[SW-1:0];
                dat_w_q  <= s.dat_w;
                sel_q    <= s.sel;
                we_q     <= s.we;
                sel_oh_q <= hit;
            end
        end
    end

`ifdef WB_PERIPH_IC_TIMEOUT_EN
    // Watchdog counter: held at zero in IDLE so every ACTIVE phase starts fresh.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_q <= '0;
        end else if (active) begin
            timer_q <= timer_q + 16'd1;
        end else begin
            timer_q <= '0;
        end
    end

    // Sticky timeout status; a new timeout beats a simultaneous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            to_valid_q <= 1'b0;
            to_addr_q  <= '0;
        end else if (to_fire) begin
            to_valid_q <= 1'b1;
            if (!to_valid_q) begin
                to_addr_q <= off_q;
            end
        end else if (to_clr) begin
            to_valid_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_wb_periph_ic_1xn.sv
// Self-checking bench for wb_periph_ic_1xn with the four-slave peripheral map.
// Build with WB_PERIPH_IC_TIMEOUT_EN to include the watchdog scenarios.
module tb_wb_periph_ic_1xn;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 12;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic to_clr = 1'b0;

    wb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [N*DW-1:0] m_dat_r;
    logic [N-1:0]    m_ack, m_err;
    logic            to_valid;
    logic [SW-1:0]   to_addr;

    // Slave behaviour knobs: wait states, response kind (bit0 ack, bit1 err), read data.
    int          wait_cfg [N];
    logic [1:0]  resp_mode[N];
    logic [31:0] rdata    [N];
    int          cnt      [N];
    logic [N-1:0] noise_ack = '0;
    logic [N-1:0] noise_err = '0;

    int base_a[N] = '{'h000, 'h400, 'h440, 'h450};
    int lim_a [N] = '{'h3FF, 'h43F, 'h44F, 'h45F};

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;

    wb_periph_ic_1xn #(
        .WB_ADDR_WIDTH(AW), .WB_DATA_WIDTH(DW), .SUBSYS_ADDR_WIDTH(SW), .N_SLAVES(N),
        .SLAVE_ADDR_BASE ({12'h450, 12'h440, 12'h400, 12'h000}),
        .SLAVE_ADDR_LIMIT({12'h45F, 12'h44F, 12'h43F, 12'h3FF}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .s(bus),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_sel(m_sel), .m_we(m_we),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .to_valid(to_valid), .to_addr(to_addr), .to_clr(to_clr)
    );

    always #5 clk = ~clk;

    // Peripheral models: respond after wait_cfg strobed cycles; noise hits idle slaves.
    always_comb begin
        m_ack   = '0;
        m_err   = '0;
        m_dat_r = '0;
        for (int i = 0; i < N; i++) begin
            m_ack[i] = (m_stb[i] && cnt[i] >= wait_cfg[i] && resp_mode[i][0]) || noise_ack[i];
            m_err[i] = (m_stb[i] && cnt[i] >= wait_cfg[i] && resp_mode[i][1]) || noise_err[i];
            m_dat_r[i*DW +: DW] = rdata[i];
        end
    end

    always @(posedge clk) begin
        cycle_no <= cycle_no + 1;
        for (int i = 0; i < N; i++) begin
            cnt[i] <= (m_stb[i] && !m_ack[i] && !m_err[i]) ? cnt[i] + 1 : 0;
        end
    end

    // Reference address map: first slave whose window contains the offset, else -1.
    function automatic int ref_decode(input logic [SW-1:0] off);
        for (int i = 0; i < N; i++) begin
            if (int'(off) >= base_a[i] && int'(off) <= lim_a[i]) return i;
        end
        return -1;
    endfunction

    task automatic bus_idle();
        bus.adr = '0; bus.dat_w = '0; bus.sel = '0; bus.we = 1'b0;
        bus.cyc = 1'b0; bus.stb = 1'b0;
    endtask

    // One complete transfer, compared cycle by cycle with the reference map and slave knobs.
    task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdat,
                            input logic [3:0] sel);
        int idx, exp_lat, n;
        logic exp_err, chk_dat, done;
        logic [31:0] exp_dat;
        logic [N-1:0] oh;
        idx = ref_decode(addr[SW-1:0]);
        oh = '0;
        exp_dat = '0;
        exp_err = 1'b1;
        chk_dat = 1'b1;
        exp_lat = 1;
        if (idx >= 0) begin
            oh[idx] = 1'b1;
            if (resp_mode[idx] == 2'b00) begin
                exp_lat = TO + 1;
            end else begin
                exp_lat = 2 + wait_cfg[idx];
                exp_err = resp_mode[idx][1];
                exp_dat = rdata[idx];
                chk_dat = !exp_err && !we;
            end
        end
        bus.adr = addr; bus.we = we; bus.dat_w = wdat; bus.sel = sel;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.ack || bus.err) begin
                done = 1'b1;
                bus.cyc = 1'b0; bus.stb = 1'b0;
                checks++;
                if (n !== exp_lat) begin
                    errors++; $display("FAIL latency @%h: got %0d expected %0d", addr, n, exp_lat);
                end
                checks++;
                if ({bus.ack, bus.err} !== {!exp_err, exp_err}) begin
                    errors++; $display("FAIL resp_kind @%h: ack/err got %b%b expected %b%b",
                                       addr, bus.ack, bus.err, !exp_err, exp_err);
                end
                if (chk_dat) begin
                    checks++;
                    if (bus.dat_r !== exp_dat) begin
                        errors++; $display("FAIL dat_r @%h: got %h expected %h", addr, bus.dat_r, exp_dat);
                    end
                end
                checks++;
                if ({m_cyc, m_stb} !== '0) begin
                    errors++; $display("FAIL stb_drop @%h: got %b expected 0", addr, m_stb);
                end
            end else begin
                checks++;
                if ({m_cyc, m_stb, m_we} !== {oh, oh, we ? oh : 4'b0}) begin
                    errors++; $display("FAIL ctrl @%h cyc%0d: cyc/stb/we got %b %b %b expected %b %b %b",
                                       addr, n, m_cyc, m_stb, m_we, oh, oh, we ? oh : 4'b0);
                end
                if (n == 1 && idx >= 0) begin
                    checks++;
                    if ({m_adr[idx*AW +: AW], m_dat_w[idx*DW +: DW], m_sel[idx*4 +: 4]} !==
                        {20'h0, addr[SW-1:0], wdat, sel}) begin
                        errors++; $display("FAIL bcast @%h: adr %h dat %h sel %h expected %h %h %h",
                                           addr, m_adr[idx*AW +: AW], m_dat_w[idx*DW +: DW],
                                           m_sel[idx*4 +: 4], {20'h0, addr[SW-1:0]}, wdat, sel);
                    end
                end
            end
        end
        if (!done) begin
            bus_idle();
            checks++; errors++;
            $display("FAIL no_response @%h: got none within 200 cycles expected one", addr);
        end
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.err} !== 2'b00) begin
            errors++; $display("FAIL resp_pulse @%h: ack/err got %b%b expected 00", addr, bus.ack, bus.err);
        end
    endtask

    task automatic set_slaves(input int w, input logic [1:0] mode);
        for (int i = 0; i < N; i++) begin
            wait_cfg[i] = w; resp_mode[i] = mode; rdata[i] = 32'h1000_0000 + i;
        end
    endtask

    task automatic test_reset();
        bus_idle();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ack, bus.err, bus.dat_r} !== '0) begin
            errors++; $display("FAIL reset_up: ack/err/dat_r got %b%b%h expected 0", bus.ack, bus.err, bus.dat_r);
        end
        checks++;
        if ({m_adr, m_dat_w, m_sel, m_we, m_cyc, m_stb} !== '0) begin
            errors++; $display("FAIL reset_down: stb %b adr %h expected 0", m_stb, m_adr);
        end
        checks++;
        if ({to_valid, to_addr} !== '0) begin
            errors++; $display("FAIL reset_to: got %b %h expected 0 000", to_valid, to_addr);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        set_slaves(0, 2'b01);
        rdata[1] = 32'hA5A5_0001;
        run_xfer(32'hFFFF_F404, 1'b0, 32'h0, 4'hF);
        wait_cfg[2] = 2;
        run_xfer(32'h0000_0448, 1'b1, 32'hDEAD_BEEF, 4'h3);
        run_xfer(32'h0000_0800, 1'b0, 32'h0, 4'hF);
        resp_mode[3] = 2'b11;
        run_xfer(32'h0000_0455, 1'b0, 32'h0, 4'hF);
        resp_mode[3] = 2'b01;
    endtask

    task automatic test_random();
        logic [31:0] r, addr;
        int pick, off, idx;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                wait_cfg[i] = $urandom_range(0, 4);
                resp_mode[i] = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
                rdata[i] = $urandom();
            end
            pick = $urandom_range(0, 4);
            off = (pick < 4) ? base_a[pick] + $urandom_range(0, lim_a[pick] - base_a[pick])
                             : $urandom_range('h460, 'hFFF);
            r = $urandom();
            addr = {r[31:12], 12'(off)};
            idx = ref_decode(addr[SW-1:0]);
            noise_ack = 4'($urandom());
            noise_err = 4'($urandom());
            if (idx >= 0) begin
                noise_ack[idx] = 1'b0;
                noise_err[idx] = 1'b0;
            end
            run_xfer(addr, 1'($urandom()), $urandom(), 4'($urandom()));
        end
        noise_ack = '0;
        noise_err = '0;
    endtask

    task automatic test_back_to_back();
        int c0;
        set_slaves(0, 2'b01);
        c0 = cycle_no;
        run_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF);
        run_xfer(32'h0000_0420, 1'b0, 32'h0, 4'hF);
        run_xfer(32'h0000_0444, 1'b0, 32'h0, 4'hF);
        checks++;
        if (cycle_no - c0 !== 9) begin
            errors++; $display("FAIL back_to_back: got %0d cycles expected 9", cycle_no - c0);
        end
    endtask

    task automatic test_abort();
        logic seen;
        set_slaves(0, 2'b01);
        wait_cfg[0] = 5;
        bus.adr = 32'h10; bus.we = 1'b0; bus.sel = 4'hF; bus.cyc = 1'b1; bus.stb = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (m_stb !== 4'b0001) begin
            errors++; $display("FAIL abort_open: stb got %b expected 0001", m_stb);
        end
        bus_idle();
        @(negedge clk);
        checks++;
        if ({m_cyc, m_stb} !== '0) begin
            errors++; $display("FAIL abort_drop: stb got %b expected 0000", m_stb);
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.ack | bus.err;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL abort_resp: got response %b expected none", seen);
        end
        run_xfer(32'h0000_0404, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_reset_mid();
        set_slaves(5, 2'b01);
        bus.adr = 32'h404; bus.we = 1'b1; bus.dat_w = 32'h1234_5678; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.ack, bus.err, bus.dat_r, m_adr, m_dat_w, m_sel, m_we, m_cyc, m_stb} !== '0) begin
            errors++; $display("FAIL reset_mid: stb %b adr %h dat_r %h expected all 0", m_stb, m_adr, bus.dat_r);
        end
        bus_idle();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        set_slaves(1, 2'b01);
        run_xfer(32'h0000_0404, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic test_timeout();
`ifdef WB_PERIPH_IC_TIMEOUT_EN
        set_slaves(0, 2'b01);
        resp_mode[0] = 2'b00;
        run_xfer(32'h0000_0010, 1'b0, 32'h0, 4'hF);
        checks++;
        if ({to_valid, to_addr} !== {1'b1, 12'h010}) begin
            errors++; $display("FAIL to_first: got %b %h expected 1 010", to_valid, to_addr);
        end
        run_xfer(32'h0000_0020, 1'b0, 32'h0, 4'hF);
        checks++;
        if ({to_valid, to_addr} !== {1'b1, 12'h010}) begin
            errors++; $display("FAIL to_second: got %b %h expected 1 010", to_valid, to_addr);
        end
        to_clr = 1'b1;
        @(negedge clk);
        to_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (to_valid !== 1'b0) begin
            errors++; $display("FAIL to_clr: got %b expected 0", to_valid);
        end
        resp_mode[0] = 2'b01;
`else
        to_clr = 1'b1;
        @(negedge clk);
        to_clr = 1'b0;
        @(negedge clk);
        checks++;
        if ({to_valid, to_addr} !== '0) begin
            errors++; $display("FAIL to_tied: got %b %h expected 0 000", to_valid, to_addr);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) cnt[i] = 0;
        set_slaves(0, 2'b01);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
